// File: rtl/depth_plotter_pkg.sv
// rtl/depth_plotter_pkg.sv - shared state encoding, depth constants and address helper
package depth_plotter_pkg;

    localparam int DEPTH_W = 8;
    localparam logic [DEPTH_W-1:0] CLEAR_DEPTH = '0;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic int pix_addr_w(input int n_pix);
        return (n_pix > 1) ? $clog2(n_pix) : 1;
    endfunction

endpackage

// File: rtl/depth_ram.sv
// rtl/depth_ram.sv - single write port, synchronous read-first depth buffer RAM
module depth_ram
    import depth_plotter_pkg::*;
#(
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17,
    parameter int DATA_W = DEPTH_W
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both accesses in one process so a same-edge read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/depth_plotter.sv
// rtl/depth_plotter.sv - z-buffered point plotter with per-frame clear sweep
module depth_plotter
    import depth_plotter_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = pix_addr_w(320 * 240)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_clear,
    input  logic               point_valid,
    output logic               point_ready,
    input  logic [9:0]         point_x,
    input  logic [9:0]         point_y,
    input  logic [DEPTH_W-1:0] point_depth,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [DEPTH_W-1:0] fb_data,
    output logic               busy
);

    localparam int N_PIX = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   sweep;
    logic                accept, in_range;
    logic [ADDR_W-1:0]   point_addr;

    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic [DEPTH_W-1:0]  s1_depth;

    logic [DEPTH_W-1:0]  ram_rdata, stored;
    logic                win;

    logic                fwd_valid;
    logic [ADDR_W-1:0]   fwd_addr;
    logic [DEPTH_W-1:0]  fwd_data;

    logic                s2_win;
    logic [ADDR_W-1:0]   s2_addr;
    logic [DEPTH_W-1:0]  s2_data;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DEPTH_W-1:0]  ram_wdata;

    assign point_ready = (state == ST_RUN);
    assign busy        = (state != ST_RUN);
    assign accept      = point_valid && point_ready;
    assign in_range    = (32'(point_x) < 32'(WIDTH)) && (32'(point_y) < 32'(HEIGHT));
    assign point_addr  = ADDR_W'(32'(point_y) * 32'(WIDTH) + 32'(point_x));

    // The previous winner's RAM write lands on the same edge this point was read, so prefer it.
    assign stored = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : ram_rdata;
    assign win    = s1_valid && (s1_depth > stored);

    always_comb begin
        ram_we    = win;
        ram_waddr = s1_addr;
        ram_wdata = s1_depth;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep;
            ram_wdata = CLEAR_DEPTH;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_CLEAR: if (!frame_clear && (sweep == LAST_ADDR)) state_nx = ST_RUN;
            ST_RUN:   if (frame_clear) state_nx = ST_DRAIN;
            ST_DRAIN: if (!s1_valid) state_nx = ST_CLEAR;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    depth_ram #(
        .DEPTH  (N_PIX),
        .ADDR_W (ADDR_W),
        .DATA_W (DEPTH_W)
    ) u_depth_ram (
        .clk   (clk),
        .re    (accept && in_range),
        .raddr (point_addr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            sweep     <= '0;
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_depth  <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            s2_win    <= 1'b0;
            s2_addr   <= '0;
            s2_data   <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
        end else begin
            state <= state_nx;

            if ((state != ST_CLEAR) || frame_clear || (sweep == LAST_ADDR)) begin
                sweep <= '0;
            end else begin
                sweep <= sweep + ADDR_W'(1);
            end

            s1_valid <= accept && in_range;
            if (accept) begin
                s1_addr  <= point_addr;
                s1_depth <= point_depth;
            end

            // The sweep zeroes every RAM word, so any held forward value goes stale.
            if (state == ST_CLEAR) begin
                fwd_valid <= 1'b0;
            end else if (win) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= s1_addr;
                fwd_data  <= s1_depth;
            end

            s2_win  <= win;
            s2_addr <= s1_addr;
            s2_data <= s1_depth;

            if (state == ST_CLEAR) begin
                fb_we   <= 1'b1;
                fb_addr <= sweep;
                fb_data <= CLEAR_DEPTH;
            end else begin
                fb_we   <= s2_win;
                fb_addr <= s2_addr;
                fb_data <= s2_data;
            end
        end
    end

endmodule

// File: tb/tb_depth_plotter.sv
// tb/tb_depth_plotter.sv - directed vector bench for depth_plotter
module tb_depth_plotter;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 32;
    localparam int ADDR_W = 17;
    localparam int N_PIX  = WIDTH * HEIGHT;
    localparam int NV     = 12;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  d;
        logic        we;
        logic [16:0] addr;
        logic [7:0]  data;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_clear;
    logic              point_valid;
    logic              point_ready;
    logic [9:0]        point_x;
    logic [9:0]        point_y;
    logic [7:0]        point_depth;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs [NV];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    always #5 clk = ~clk;

    depth_plotter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_clear (frame_clear),
        .point_valid (point_valid),
        .point_ready (point_ready),
        .point_x     (point_x),
        .point_y     (point_y),
        .point_depth (point_depth),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},   point_ready, 0);
        check({tag, "_fb_we"},   fb_we, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
        check({tag, "_busy"},    busy, 1);
    endtask

    // Observes strobes first..N_PIX-1 of a clear sweep, then the return to RUN.
    task automatic run_sweep(input int first);
        int bad = 0;
        for (int i = first; i < N_PIX; i++) begin
            step();
            if (i == 0) check("sweep_busy_at_start", busy, 1);
            if (!(fb_we === 1'b1 && fb_addr === ADDR_W'(i) && fb_data === 8'd0)) bad++;
        end
        check("sweep_bad_strobes", bad, 0);
        step();
        check("post_sweep_fb_we", fb_we, 0);
        check("post_sweep_ready", point_ready, 1);
        check("post_sweep_busy", busy, 0);
    endtask

    task automatic point_check(input string tag, input logic [9:0] x, input logic [9:0] y,
                               input logic [7:0] d, input logic exp_we,
                               input logic [31:0] exp_addr, input logic [31:0] exp_data);
        check({tag, "_ready"}, point_ready, 1);
        point_x = x; point_y = y; point_depth = d; point_valid = 1'b1;
        step();
        point_valid = 1'b0;
        step();
        check({tag, "_no_early_we"}, fb_we, 0);
        step();
        check({tag, "_we"}, fb_we, exp_we);
        if (exp_we) begin
            check({tag, "_addr"}, fb_addr, exp_addr);
            check({tag, "_data"}, fb_data, exp_data);
        end
        step();
    endtask

    task automatic collect(input int cycles);
        wr_addr.delete();
        wr_data.delete();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (fb_we === 1'b1) begin
                wr_addr.push_back(32'(fb_addr));
                wr_data.push_back(32'(fb_data));
            end
        end
    endtask

    task automatic send_pair(input logic [9:0] x, input logic [9:0] y,
                             input logic [7:0] d0, input logic [7:0] d1);
        point_x = x; point_y = y; point_valid = 1'b1;
        point_depth = d0;
        step();
        point_depth = d1;
        step();
        point_valid = 1'b0;
        collect(5);
    endtask

    initial begin
        int found;

        vecs[0]  = '{10'd10,   10'd20,   8'd50,  1'b1, 17'd6410,  8'd50};
        vecs[1]  = '{10'd320,  10'd0,    8'd99,  1'b0, 17'd0,     8'd0};
        vecs[2]  = '{10'd0,    10'd32,   8'd99,  1'b0, 17'd0,     8'd0};
        vecs[3]  = '{10'd1023, 10'd5,    8'd99,  1'b0, 17'd0,     8'd0};
        vecs[4]  = '{10'd0,    10'd240,  8'd99,  1'b0, 17'd0,     8'd0};
        vecs[5]  = '{10'd0,    10'd0,    8'd1,   1'b1, 17'd0,     8'd1};
        vecs[6]  = '{10'd10,   10'd20,   8'd50,  1'b0, 17'd0,     8'd0};
        vecs[7]  = '{10'd10,   10'd20,   8'd49,  1'b0, 17'd0,     8'd0};
        vecs[8]  = '{10'd10,   10'd20,   8'd51,  1'b1, 17'd6410,  8'd51};
        vecs[9]  = '{10'd319,  10'd31,   8'd255, 1'b1, 17'd10239, 8'd255};
        vecs[10] = '{10'd0,    10'd0,    8'd0,   1'b0, 17'd0,     8'd0};
        vecs[11] = '{10'd1023, 10'd1023, 8'd255, 1'b0, 17'd0,     8'd0};

        reset = 1'b1; frame_clear = 1'b0; point_valid = 1'b0;
        point_x = '0; point_y = '0; point_depth = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;
        run_sweep(0);

        for (int k = 0; k < NV; k++) begin
            point_check($sformatf("vec%0d", k), vecs[k].x, vecs[k].y, vecs[k].d,
                        vecs[k].we, 32'(vecs[k].addr), 32'(vecs[k].data));
        end

        send_pair(10'd100, 10'd10, 8'd50, 8'd80);
        check("b2b_up_count", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("b2b_up_addr0", wr_addr[0], 3300);
            check("b2b_up_data0", wr_data[0], 50);
            check("b2b_up_addr1", wr_addr[1], 3300);
            check("b2b_up_data1", wr_data[1], 80);
        end

        send_pair(10'd101, 10'd10, 8'd80, 8'd50);
        check("b2b_down_count", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("b2b_down_addr", wr_addr[0], 3301);
            check("b2b_down_data", wr_data[0], 80);
        end

        point_x = 10'd5; point_y = 10'd5; point_depth = 8'd200; point_valid = 1'b1;
        step();
        point_valid = 1'b0; frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        check("fc_ready_low", point_ready, 0);
        check("fc_busy_high", busy, 1);
        step();
        check("fc_inflight_we", fb_we, 1);
        check("fc_inflight_addr", fb_addr, 1605);
        check("fc_inflight_data", fb_data, 200);
        found = 0;
        for (int c = 0; c < 3 && found == 0; c++) begin
            step();
            if (fb_we === 1'b1) found = 1;
        end
        check("fc_strobe_within_bound", found, 1);
        check("fc_first_strobe_addr", fb_addr, 0);
        check("fc_first_strobe_data", fb_data, 0);
        run_sweep(1);
        point_check("after_clear", 10'd5, 10'd5, 8'd10, 1'b1, 1605, 10);

        point_x = 10'd7; point_y = 10'd7; point_depth = 8'd90; point_valid = 1'b1;
        step();
        point_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_reset_values("rst_stream");
        reset = 1'b0;
        repeat (50) step();
        check("mid_sweep_we", fb_we, 1);
        check("mid_sweep_addr", fb_addr, 49);
        #2 reset = 1'b1;
        #1;
        check_reset_values("rst_sweep");
        reset = 1'b0;
        run_sweep(0);
        point_check("after_reset", 10'd7, 10'd7, 8'd90, 1'b1, 2247, 90);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
